gshare_fetch_predictor: RTL and testbench

//  N-lane branch predictor for the fetch1 stage: gshare PHT, tagged BTB with valid bits, speculative GHR with mispredict repair.

---
 rtl/gshare_fetch_predictor_pkg.sv | 32 +++
 rtl/gshare_fetch_predictor_btb_bank.sv | 61 ++++++
 rtl/gshare_fetch_predictor.sv | 216 +++++++++++++++++++++
 tb/tb_gshare_fetch_predictor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gshare_fetch_predictor_pkg.sv
// Shared definitions for the gshare fetch predictor: FSM states, counter
// reset value, update-control payload and the 2-bit saturating counter step.
package gshare_fetch_predictor_pkg;

  localparam int unsigned PC_W = 32;

  // Weakly-not-taken: value every PHT counter is swept to after reset
  localparam logic [1:0] BP_CTR_WNT = 2'b01;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Decoded actions for one resolved control-flow update
  typedef struct packed {
    logic pht_we;       // write PHT counter
    logic pht_inc;      // 1 = increment, 0 = decrement
    logic btb_wr;       // install/refresh BTB entry
    logic btb_inv;      // drop BTB entry if it still matches
    logic commit_shift; // shift resolved direction into committed GHR
  } upd_ctl_t;

  // Saturating 2-bit counter step, clamped to 0..3
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic inc);
    if (inc) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/gshare_fetch_predictor_btb_bank.sv
// Tagged BTB bank: valid/tag/target arrays with FETCH_W combinational lookup
// ports (tag compare done here), one install port, one conditional
// invalidate port and one clear port used by the post-reset sweep.
// Ports:
//   clk                         clock
//   clr_en, clr_idx             clear valid bit of one entry (sweep)
//   wr_en, wr_idx/tag/tgt       install valid entry
//   inv_en, inv_idx/tag         clear valid if entry is valid and tag matches
//   rd_idx, rd_tag              per-lane lookup index and tag
//   rd_hit, rd_tgt              per-lane valid&&tag-match and stored target
module gshare_fetch_predictor_btb_bank
  import gshare_fetch_predictor_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ABITS   = 10
) (
  input  logic                                  clk,
  input  logic                                  clr_en,
  input  logic [ABITS-1:0]                      clr_idx,
  input  logic                                  wr_en,
  input  logic [ABITS-1:0]                      wr_idx,
  input  logic [PC_W-ABITS-3:0]                 wr_tag,
  input  logic [PC_W-1:0]                       wr_tgt,
  input  logic                                  inv_en,
  input  logic [ABITS-1:0]                      inv_idx,
  input  logic [PC_W-ABITS-3:0]                 inv_tag,
  input  logic [FETCH_W-1:0][ABITS-1:0]         rd_idx,
  input  logic [FETCH_W-1:0][PC_W-ABITS-3:0]    rd_tag,
  output logic [FETCH_W-1:0]                    rd_hit,
  output logic [FETCH_W-1:0][PC_W-1:0]          rd_tgt
);

  localparam int unsigned ENTRIES = 1 << ABITS;
  localparam int unsigned TAG_W   = PC_W - ABITS - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];

  // Array writes; sweep, install and invalidate are mutually exclusive upstream
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      tgt_q[wr_idx]   <= wr_tgt;
    end else if (inv_en && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag)) begin
      valid_q[inv_idx] <= 1'b0;
    end
  end

  // Lookup ports read pre-write contents, so same-cycle writes show next cycle
  always_comb begin
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      rd_hit[k] = valid_q[rd_idx[k]] && (tag_q[rd_idx[k]] == rd_tag[k]);
      rd_tgt[k] = tgt_q[rd_idx[k]];
    end
  end

endmodule

// File: rtl/gshare_fetch_predictor.sv
// N-lane fetch1 branch predictor: gshare PHT, tagged BTB, speculative GHR
// with repair from the committed GHR, and a post-reset table sweep.
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   ready_o                     0 while tables are being swept
//   lookup_we_i, lookup_pc_i    latch next fetch-group PC
//   hit_o, taken_o              per-lane BTB hit / predicted taken
//   redirect_o, lane_o, tgt_o   any taken, lowest taken lane, its target
//   ghr_o                       speculative GHR used for this lookup
//   update_*                    resolved control-flow update from execute
//   mispredict_i                restore speculative GHR from committed GHR
module gshare_fetch_predictor
  import gshare_fetch_predictor_pkg::*;
#(
  parameter int unsigned FETCH_W  = 2,
  parameter int unsigned ABITS    = 10,
  parameter int unsigned GHR_BITS = 10,
  parameter int unsigned HASH_EN  = 1,
  localparam int unsigned LANE_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  output logic                ready_o,
  input  logic                lookup_we_i,
  input  logic [31:0]         lookup_pc_i,
  output logic [FETCH_W-1:0]  hit_o,
  output logic [FETCH_W-1:0]  taken_o,
  output logic                redirect_o,
  output logic [LANE_W-1:0]   lane_o,
  output logic [31:0]         tgt_o,
  output logic [GHR_BITS-1:0] ghr_o,
  input  logic                update_i,
  input  logic [31:0]         update_pc_i,
  input  logic [GHR_BITS-1:0] update_ghr_i,
  input  logic                update_br_i,
  input  logic                update_taken_i,
  input  logic [31:0]         update_tgt_i,
  input  logic                mispredict_i
);

  localparam int unsigned ENTRIES = 1 << ABITS;
  localparam int unsigned TAG_W   = PC_W - ABITS - 2;
  localparam int unsigned WORD_W  = PC_W - 2;

  bp_state_e            state_q, state_d;
  logic [ABITS-1:0]     sweep_q, sweep_d;
  logic                 clr_en;
  logic                 run;

  logic [WORD_W-1:0]    pc_word_q;
  logic [GHR_BITS-1:0]  ghr_spec_q, ghr_spec_d;
  logic [GHR_BITS-1:0]  ghr_commit_q, ghr_commit_d;

  logic [1:0]           pht_q [ENTRIES];

  logic [FETCH_W-1:0][WORD_W-1:0] lane_word;
  logic [FETCH_W-1:0][ABITS-1:0]  lane_idx;
  logic [FETCH_W-1:0][TAG_W-1:0]  lane_tag;
  logic [FETCH_W-1:0][ABITS-1:0]  lane_pht_idx;
  logic [FETCH_W-1:0]             bank_hit;
  logic [FETCH_W-1:0][PC_W-1:0]   bank_tgt;
  logic [ABITS-1:0]               spec_hash;

  logic [ABITS-1:0]     upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic [ABITS-1:0]     upd_pht_idx;
  upd_ctl_t             upd_ctl;

  // Byte-offset bits never reach the tables
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  // Init/run FSM state register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= BP_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep one table index per cycle, then run
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_en  = 1'b0;
    case (state_q)
      BP_INIT: begin
        clr_en  = 1'b1;
        sweep_d = sweep_q + ABITS'(1);
        if (sweep_q == '1) begin
          state_d = BP_RUN;
        end
      end
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  assign run     = (state_q == BP_RUN);
  assign ready_o = run;

  // Lane addressing: PC + 4k done on the word address, which is identical
  assign spec_hash = (HASH_EN != 0) ? ABITS'(ghr_spec_q) : '0;

  always_comb begin
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      lane_word[k]    = pc_word_q + WORD_W'(k);
      lane_idx[k]     = lane_word[k][ABITS-1:0];
      lane_tag[k]     = lane_word[k][WORD_W-1:ABITS];
      lane_pht_idx[k] = lane_idx[k] ^ spec_hash;
    end
  end

  gshare_fetch_predictor_btb_bank #(
    .FETCH_W (FETCH_W),
    .ABITS   (ABITS)
  ) u_btb (
    .clk     (clock_i),
    .clr_en  (clr_en),
    .clr_idx (sweep_q),
    .wr_en   (upd_ctl.btb_wr),
    .wr_idx  (upd_idx),
    .wr_tag  (upd_tag),
    .wr_tgt  (update_tgt_i),
    .inv_en  (upd_ctl.btb_inv),
    .inv_idx (upd_idx),
    .inv_tag (upd_tag),
    .rd_idx  (lane_idx),
    .rd_tag  (lane_tag),
    .rd_hit  (bank_hit),
    .rd_tgt  (bank_tgt)
  );

  // Per-lane prediction and lowest-taken-lane priority encode
  always_comb begin
    hit_o      = '0;
    taken_o    = '0;
    redirect_o = 1'b0;
    lane_o     = '0;
    tgt_o      = '0;
    if (run) begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        hit_o[k]   = bank_hit[k];
        taken_o[k] = bank_hit[k] && pht_q[lane_pht_idx[k]][1];
      end
      for (int k = FETCH_W - 1; k >= 0; k--) begin
        if (taken_o[k]) begin
          lane_o = LANE_W'(k);
        end
      end
      redirect_o = |taken_o;
      tgt_o      = bank_tgt[lane_o];
    end
  end

  assign ghr_o = ghr_spec_q;

  // Update decode; a false branch drops its BTB entry and weakens the counter
  // that produced the taken prediction
  assign upd_idx     = update_pc_i[ABITS+1:2];
  assign upd_tag     = update_pc_i[PC_W-1:ABITS+2];
  assign upd_pht_idx = upd_idx ^ ((HASH_EN != 0) ? ABITS'(update_ghr_i) : '0);

  always_comb begin
    upd_ctl              = '0;
    upd_ctl.pht_we       = run && update_i;
    upd_ctl.pht_inc      = update_br_i && update_taken_i;
    upd_ctl.btb_wr       = run && update_i && update_br_i && update_taken_i;
    upd_ctl.btb_inv      = run && update_i && !update_br_i;
    upd_ctl.commit_shift = run && update_i && update_br_i;
  end

  // PHT writes: sweep to weakly-not-taken, else saturating training
  always_ff @(posedge clock_i) begin
    if (clr_en) begin
      pht_q[sweep_q] <= BP_CTR_WNT;
    end else if (upd_ctl.pht_we) begin
      pht_q[upd_pht_idx] <= ctr_next(pht_q[upd_pht_idx], upd_ctl.pht_inc);
    end
  end

  // GHR next state; a repair wins over a same-cycle speculative shift
  always_comb begin
    ghr_commit_d = ghr_commit_q;
    ghr_spec_d   = ghr_spec_q;
    if (upd_ctl.commit_shift) begin
      ghr_commit_d = GHR_BITS'({ghr_commit_q, update_taken_i});
    end
    if (run) begin
      if (update_i && mispredict_i) begin
        ghr_spec_d = ghr_commit_d;
      end else if (lookup_we_i && (|hit_o)) begin
        ghr_spec_d = GHR_BITS'({ghr_spec_q, redirect_o});
      end
    end
  end

  // Fetch PC keeps tracking pc_mux during the sweep; outputs are masked then
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_word_q    <= '0;
      ghr_spec_q   <= '0;
      ghr_commit_q <= '0;
    end else begin
      if (lookup_we_i) begin
        pc_word_q <= lookup_pc_i[PC_W-1:2];
      end
      ghr_spec_q   <= ghr_spec_d;
      ghr_commit_q <= ghr_commit_d;
    end
  end

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
// Directed bench for gshare_fetch_predictor (FETCH_W=2, ABITS=10, GHR_BITS=10).
module tb_gshare_fetch_predictor;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        ready_o;
  logic        lookup_we_i;
  logic [31:0] lookup_pc_i;
  logic [1:0]  hit_o;
  logic [1:0]  taken_o;
  logic        redirect_o;
  logic [0:0]  lane_o;
  logic [31:0] tgt_o;
  logic [9:0]  ghr_o;
  logic        update_i;
  logic [31:0] update_pc_i;
  logic [9:0]  update_ghr_i;
  logic        update_br_i;
  logic        update_taken_i;
  logic [31:0] update_tgt_i;
  logic        mispredict_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gshare_fetch_predictor #(
    .FETCH_W  (2),
    .ABITS    (10),
    .GHR_BITS (10),
    .HASH_EN  (1)
  ) dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .ready_o        (ready_o),
    .lookup_we_i    (lookup_we_i),
    .lookup_pc_i    (lookup_pc_i),
    .hit_o          (hit_o),
    .taken_o        (taken_o),
    .redirect_o     (redirect_o),
    .lane_o         (lane_o),
    .tgt_o          (tgt_o),
    .ghr_o          (ghr_o),
    .update_i       (update_i),
    .update_pc_i    (update_pc_i),
    .update_ghr_i   (update_ghr_i),
    .update_br_i    (update_br_i),
    .update_taken_i (update_taken_i),
    .update_tgt_i   (update_tgt_i),
    .mispredict_i   (mispredict_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_we_i = 1'b1;
    lookup_pc_i = pc;
    step();
    lookup_we_i = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [9:0] ghr, input logic br,
                     input logic tk, input logic [31:0] tgt, input logic mis);
    update_i       = 1'b1;
    update_pc_i    = pc;
    update_ghr_i   = ghr;
    update_br_i    = br;
    update_taken_i = tk;
    update_tgt_i   = tgt;
    mispredict_i   = mis;
    step();
    update_i     = 1'b0;
    mispredict_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; lookup_we_i = 1'b0; lookup_pc_i = '0;
    update_i = 1'b0; update_pc_i = '0; update_ghr_i = '0; update_br_i = 1'b0;
    update_taken_i = 1'b0; update_tgt_i = '0; mispredict_i = 1'b0;
    step(); step();

    // reset state
    check("rst_ready", 32'(ready_o), 0);
    check("rst_hit", 32'(hit_o), 0);
    check("rst_redirect", 32'(redirect_o), 0);
    check("rst_tgt", tgt_o, 0);
    check("rst_ghr", 32'(ghr_o), 0);

    // first sweep: 1024 cycles not ready, lookups masked
    reset_i = 1'b0;
    lookup_we_i = 1'b1;
    lookup_pc_i = 32'h3000;
    for (int i = 0; i < 1024; i++) begin
      check("sweep_ready", 32'(ready_o), 0);
      check("sweep_hit", 32'(hit_o), 0);
      step();
    end
    lookup_we_i = 1'b0;
    check("ready_rise", 32'(ready_o), 1);
    check("ready_hit", 32'(hit_o), 0);

    // single lane training at 0x40
    upd(32'h40, 10'd0, 1'b1, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 10'd0, 1'b1, 1'b1, 32'h100, 1'b0);
    look(32'h40);
    check("l40_hit", 32'(hit_o), 2'b01);
    check("l40_taken", 32'(taken_o), 2'b01);
    check("l40_redirect", 32'(redirect_o), 1);
    check("l40_lane", 32'(lane_o), 0);
    check("l40_tgt", tgt_o, 32'h100);
    check("l40_ghr", 32'(ghr_o), 0);

    // both lanes at 0x80/0x84; lookup edge shifts GHR to 1
    upd(32'h80, 10'd1, 1'b1, 1'b1, 32'h200, 1'b0);
    upd(32'h80, 10'd1, 1'b1, 1'b1, 32'h200, 1'b0);
    upd(32'h84, 10'd1, 1'b1, 1'b1, 32'h300, 1'b0);
    upd(32'h84, 10'd1, 1'b1, 1'b1, 32'h300, 1'b0);
    look(32'h80);
    check("l80_ghr", 32'(ghr_o), 1);
    check("l80_hit", 32'(hit_o), 2'b11);
    check("l80_taken", 32'(taken_o), 2'b11);
    check("l80_lane", 32'(lane_o), 0);
    check("l80_tgt", tgt_o, 32'h200);

    // counter saturation at 0x40 under GHR=3
    look(32'h40);
    check("sat_ghr", 32'(ghr_o), 3);
    for (int i = 0; i < 5; i++) upd(32'h40, 10'd3, 1'b1, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 10'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    check("sat_taken", 32'(taken_o), 2'b01);
    check("sat_tgt", tgt_o, 32'h100);
    upd(32'h40, 10'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 10'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    check("nt_taken", 32'(taken_o), 0);
    check("nt_hit", 32'(hit_o), 2'b01);
    check("nt_redirect", 32'(redirect_o), 0);

    // false branch removes BTB entry; no hit so lookup leaves GHR alone
    upd(32'h40, 10'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("inv_hit_now", 32'(hit_o), 0);
    look(32'h40);
    check("inv_hit", 32'(hit_o), 0);
    check("inv_ghr", 32'(ghr_o), 3);

    // GHR repair: clear committed history, then repair paths
    for (int i = 0; i < 10; i++) upd(32'h1000, 10'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h1000, 10'd0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("mis_nt_ghr", 32'(ghr_o), 0);
    upd(32'h1000, 10'd0, 1'b1, 1'b1, 32'h5000, 1'b0);
    check("nomis_ghr", 32'(ghr_o), 0);
    upd(32'h1000, 10'd0, 1'b1, 1'b1, 32'h5000, 1'b1);
    check("mis_t_ghr", 32'(ghr_o), 3);

    // lane priority: only lane 1 (0x80) can be taken
    look(32'h7C);
    check("p_ghr", 32'(ghr_o), 3);
    check("p_hit", 32'(hit_o), 2'b10);
    check("p_taken0", 32'(taken_o), 0);
    upd(32'h80, 10'd3, 1'b1, 1'b1, 32'h200, 1'b0);
    check("p_taken", 32'(taken_o), 2'b10);
    check("p_lane", 32'(lane_o), 1);
    check("p_tgt", tgt_o, 32'h200);
    check("p_redirect", 32'(redirect_o), 1);

    // reset at sweep cycle 500 restarts the sweep
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    lookup_we_i = 1'b1;
    lookup_pc_i = 32'h80;
    for (int i = 0; i < 500; i++) begin
      check("sw2_ready", 32'(ready_o), 0);
      step();
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      check("sw3_ready", 32'(ready_o), 0);
      check("sw3_hit", 32'(hit_o), 0);
      step();
    end
    lookup_we_i = 1'b0;
    check("sw3_rise", 32'(ready_o), 1);
    check("sw3_cleared", 32'(hit_o), 0);
    check("sw3_ghr", 32'(ghr_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
